// File: rtl/tick_gen_pkg.sv
// Shared encodings and default sizing for the tick generator and its channels.
package tick_gen_pkg;

  localparam int unsigned CNT_W_DEF   = 28;
  localparam int unsigned DIV_RST_DEF = 2500000;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_gen_chan.sv
// Single divider channel: active/shadow divisor, counter, toggle register and
// registered tick / clk_out outputs.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] d, d_n;
  logic [CNT_W-1:0] s, s_n;
  logic [CNT_W-1:0] q, q_n;
  logic             t, t_n;
  logic             imm, imm_n;
  logic             tick_n, clk_out_n;

  always_comb begin
    d_n    = d;
    s_n    = s;
    q_n    = q;
    t_n    = t;
    imm_n  = 1'b0;
    tick_n = 1'b0;
    if (clr) begin
      q_n = '0;
      d_n = s;
    end else begin
      if (div_load) begin
        s_n   = div_in;
        imm_n = (d == '0) || !en;
      end
      // A load taken while stopped/idle is copied one cycle later; a terminal
      // count in that same cycle overrides it with the freshest divisor.
      if (imm) begin
        d_n = s;
      end
      if (en && (d != '0)) begin
        if (q >= d - ONE) begin
          q_n    = '0;
          tick_n = 1'b1;
          t_n    = ~t;
          d_n    = div_load ? div_in : s;
        end else begin
          q_n = q + ONE;
        end
      end else if (d == '0) begin
        q_n = '0;
      end
    end
    clk_out_n = (mode == MODE_TOGGLE) ? t_n : tick_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= DIV_RST_V;
      s       <= DIV_RST_V;
      q       <= '0;
      t       <= 1'b0;
      imm     <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      d       <= d_n;
      s       <= s_n;
      q       <= q_n;
      t       <= t_n;
      imm     <= imm_n;
      tick    <= tick_n;
      clk_out <= clk_out_n;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator; one tick_gen_chan per channel,
// sharing reset and the phase-alignment clear.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       mode,
  input  logic                  clr,
  input  logic [N_CH-1:0]       div_load,
  input  logic [N_CH*CNT_W-1:0] div_in,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       clk_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    tick_gen_chan #(
      .CNT_W  (CNT_W),
      .DIV_RST(DIV_RST)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[i]),
      .clr     (clr),
      .div_load(div_load[i]),
      .div_in  (div_in[i*CNT_W +: CNT_W]),
      .tick    (tick[i]),
      .clk_out (clk_out[i])
    );
  end

endmodule
